// File: rtl/copy_pkg.sv
// Shared definitions for the burst_copy block.
//   - Slave register offsets (4-bit word index on slave_address)
//   - MODE register bit positions
//   - Engine state encoding
package copy_pkg;

  localparam logic [3:0] REG_CTRL    = 4'd0;  // write: start, read: {done, busy}
  localparam logic [3:0] REG_DST     = 4'd1;
  localparam logic [3:0] REG_SRC     = 4'd2;
  localparam logic [3:0] REG_NWORDS  = 4'd3;
  localparam logic [3:0] REG_MODE    = 4'd4;
  localparam logic [3:0] REG_FILL    = 4'd5;
  localparam logic [3:0] REG_DONECNT = 4'd6;  // read-only

  localparam int unsigned MODE_FILL_BIT = 0;   // 1 = fill destination, no reads

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/copy_fifo.sv
// Read-data FIFO for burst_copy.
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   push/push_data : write one entry (ignored when full unless popping)
//   pop/pop_data   : pop_data is the current head; pop advances it
//   count/full/empty : occupancy status
module copy_fifo #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push_en, pop_en;

  always_comb begin
    pop_en   = pop & (count_q != '0);
    // A push into a full FIFO is allowed only when the head leaves in the same cycle.
    push_en  = push & ((count_q != (PW+1)'(DEPTH)) | pop_en);
    wr_ptr_d = wr_ptr_q + PW'(push_en);
    rd_ptr_d = rd_ptr_q + PW'(pop_en);
    count_d  = count_q + (PW+1)'(push_en) - (PW+1)'(pop_en);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/burst_copy.sv
// burst_copy: register-programmed memory copy / fill engine.
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   slave_*    : 32-bit register port (CTRL/STATUS, DST, SRC, NWORDS, MODE,
//                FILL, DONECNT); readdata returned one cycle after read
//   master_*   : memory master; one command at a time, held under
//                waitrequest, pipelined reads returned via readdatavalid
module burst_copy
  import copy_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  output logic          slave_waitrequest,
  input  logic [3:0]    slave_address,
  input  logic          slave_read,
  output logic [31:0]   slave_readdata,
  input  logic          slave_write,
  input  logic [31:0]   slave_writedata,
  input  logic          master_waitrequest,
  output logic [AW-1:0] master_address,
  output logic          master_read,
  input  logic [DW-1:0] master_readdata,
  input  logic          master_readdatavalid,
  output logic          master_write,
  output logic [DW-1:0] master_writedata
);

  localparam int unsigned   CW   = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] STEP = AW'(DW / 8);

  state_e        state_q, state_d;
  logic [31:0]   dst_q, dst_d, src_q, src_d, nwords_q, nwords_d;
  logic [31:0]   fill_q, fill_d, donecnt_q, donecnt_d;
  logic          mode_fill_q, mode_fill_d;
  logic          done_q, done_d;
  logic [AW-1:0] cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
  logic [31:0]   reads_left_q, reads_left_d, writes_left_q, writes_left_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic          master_read_q, master_read_d, master_write_q, master_write_d;
  logic [AW-1:0] master_address_q, master_address_d;
  logic [31:0]   slave_readdata_q, slave_readdata_d;

  logic          busy, cmd_active, cmd_accept, rd_accept, wr_accept, rdv_take;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic [CW-1:0] fifo_count, count_next;
  logic [CW:0]   buffered_next;
  logic          write_avail, read_avail;
  logic [31:0]   mode_word;

  copy_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (master_readdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    busy       = (state_q != IDLE);
    cmd_active = master_read_q | master_write_q;
    rd_accept  = master_read_q & ~master_waitrequest;
    wr_accept  = master_write_q & ~master_waitrequest;
    cmd_accept = rd_accept | wr_accept;
    // Data is only taken while reads are in flight; this drops stale beats after an abort.
    rdv_take   = master_readdatavalid & (outstanding_q != '0);
    fifo_push  = rdv_take & ~fifo_full;
    fifo_pop   = wr_accept & ~mode_fill_q & ~fifo_empty;

    outstanding_d = outstanding_q + CW'(rd_accept) - CW'(rdv_take);
    count_next    = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    // Selection looks at next-cycle occupancy so a read can follow an accepted read immediately.
    buffered_next = {1'b0, count_next} + {1'b0, outstanding_d};
    write_avail   = (writes_left_q != '0) & (mode_fill_q | (count_next != '0));
    read_avail    = (reads_left_q != '0) & (buffered_next < (CW+1)'(DEPTH));

    mode_word                = '0;
    mode_word[MODE_FILL_BIT] = mode_fill_q;

    state_d          = state_q;
    dst_d            = dst_q;
    src_d            = src_q;
    nwords_d         = nwords_q;
    fill_d           = fill_q;
    mode_fill_d      = mode_fill_q;
    donecnt_d        = donecnt_q;
    done_d           = done_q;
    cur_src_d        = cur_src_q;
    cur_dst_d        = cur_dst_q;
    reads_left_d     = reads_left_q;
    writes_left_d    = writes_left_q;
    master_read_d    = master_read_q;
    master_write_d   = master_write_q;
    master_address_d = master_address_q;
    slave_readdata_d = slave_readdata_q;

    if (slave_read) begin
      unique case (slave_address)
        REG_CTRL:    slave_readdata_d = {30'b0, done_q, busy};
        REG_DST:     slave_readdata_d = dst_q;
        REG_SRC:     slave_readdata_d = src_q;
        REG_NWORDS:  slave_readdata_d = nwords_q;
        REG_MODE:    slave_readdata_d = mode_word;
        REG_FILL:    slave_readdata_d = fill_q;
        REG_DONECNT: slave_readdata_d = donecnt_q;
        default:     slave_readdata_d = '0;
      endcase
    end

    if (slave_write && !busy) begin
      unique case (slave_address)
        REG_CTRL: begin
          donecnt_d = '0;
          if (nwords_q == '0) begin
            done_d = 1'b1;
          end else begin
            done_d        = 1'b0;
            cur_src_d     = AW'(src_q);
            cur_dst_d     = AW'(dst_q);
            reads_left_d  = mode_fill_q ? '0 : nwords_q;
            writes_left_d = nwords_q;
            state_d       = RUN;
          end
        end
        REG_DST:    dst_d       = slave_writedata;
        REG_SRC:    src_d       = slave_writedata;
        REG_NWORDS: nwords_d    = slave_writedata;
        REG_MODE:   mode_fill_d = slave_writedata[MODE_FILL_BIT];
        REG_FILL:   fill_d      = slave_writedata;
        default:    ;
      endcase
    end

    if (busy) begin
      if (wr_accept) donecnt_d = donecnt_q + 32'd1;
      if (cmd_accept) begin
        master_read_d    = 1'b0;
        master_write_d   = 1'b0;
        master_address_d = '0;
      end
      // reads_left / writes_left count commands not yet issued.
      if (!cmd_active || cmd_accept) begin
        if (write_avail) begin
          master_write_d   = 1'b1;
          master_address_d = cur_dst_q;
          cur_dst_d        = cur_dst_q + STEP;
          writes_left_d    = writes_left_q - 32'd1;
        end else if (read_avail) begin
          master_read_d    = 1'b1;
          master_address_d = cur_src_q;
          cur_src_d        = cur_src_q + STEP;
          reads_left_d     = reads_left_q - 32'd1;
        end
      end
      unique case (state_q)
        RUN:     if (reads_left_q == '0) state_d = DRAIN;
        DRAIN:   if (writes_left_q == '0 && wr_accept) begin
                   state_d = IDLE;
                   done_d  = 1'b1;
                 end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      dst_q            <= '0;
      src_q            <= '0;
      nwords_q         <= '0;
      fill_q           <= '0;
      mode_fill_q      <= 1'b0;
      donecnt_q        <= '0;
      done_q           <= 1'b0;
      cur_src_q        <= '0;
      cur_dst_q        <= '0;
      reads_left_q     <= '0;
      writes_left_q    <= '0;
      outstanding_q    <= '0;
      master_read_q    <= 1'b0;
      master_write_q   <= 1'b0;
      master_address_q <= '0;
      slave_readdata_q <= '0;
    end else begin
      state_q          <= state_d;
      dst_q            <= dst_d;
      src_q            <= src_d;
      nwords_q         <= nwords_d;
      fill_q           <= fill_d;
      mode_fill_q      <= mode_fill_d;
      donecnt_q        <= donecnt_d;
      done_q           <= done_d;
      cur_src_q        <= cur_src_d;
      cur_dst_q        <= cur_dst_d;
      reads_left_q     <= reads_left_d;
      writes_left_q    <= writes_left_d;
      outstanding_q    <= outstanding_d;
      master_read_q    <= master_read_d;
      master_write_q   <= master_write_d;
      master_address_q <= master_address_d;
      slave_readdata_q <= slave_readdata_d;
    end
  end

  assign slave_waitrequest = 1'b0;
  assign slave_readdata    = slave_readdata_q;
  assign master_read       = master_read_q;
  assign master_write      = master_write_q;
  assign master_address    = master_address_q;
  // Write data comes straight from the FIFO head, which stays put until the write is accepted.
  assign master_writedata  = master_write_q ? (mode_fill_q ? DW'(fill_q) : fifo_rdata) : '0;

endmodule

// File: tb/tb_burst_copy.sv
// Self-checking bench for burst_copy: memory model with configurable
// readdatavalid latency and optional random waitrequest; expected master
// reads/writes queued at job setup and popped by the memory-side monitor.
module tb_burst_copy;
  import copy_pkg::*;

  localparam int unsigned DW = 32, AW = 32, DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          slave_waitrequest;
  logic [3:0]    slave_address;
  logic          slave_read, slave_write;
  logic [31:0]   slave_readdata, slave_writedata;
  logic          master_waitrequest;
  logic [AW-1:0] master_address;
  logic          master_read, master_write;
  logic [DW-1:0] master_readdata, master_writedata;
  logic          master_readdatavalid;

  burst_copy #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { int due; logic [31:0] data; } pend_t;

  int          n_tests = 0, n_fail = 0;
  logic [31:0] exp_rd_q[$];
  wr_t         exp_wr_q[$];
  pend_t       pend_q[$];
  int          cyc = 0, lat = 1;
  bit          wait_rand = 1'b0;
  int          rd_acc = 0, wr_acc = 0, max_inflight = 0, strobes = 0;
  int          rd_cyc[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Memory model and monitor: decides waitrequest, records acceptances, returns read data.
  initial begin : mem_model
    logic        wr_stall, prev_wait, prev_rst, prev_rd, prev_wr;
    logic [31:0] prev_addr, prev_wdata;
    wr_t         e;
    master_waitrequest   = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata      = '0;
    prev_wait = 1'b0; prev_rst = 1'b1; prev_rd = 1'b0; prev_wr = 1'b0;
    prev_addr = '0; prev_wdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!prev_rst && prev_wait && (prev_rd || prev_wr)) begin
        check("hold_addr", master_address, prev_addr);
        check("hold_strobes", {30'b0, master_read, master_write}, {30'b0, prev_rd, prev_wr});
        if (prev_wr) check("hold_wdata", master_writedata, prev_wdata);
      end
      if (master_read && master_write) begin
        n_tests++; n_fail++;
        $display("FAIL one_cmd: read and write both asserted at %08h", master_address);
      end
      if (master_read || master_write) strobes++;
      wr_stall = wait_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
      master_waitrequest = wr_stall;
      if (!rst && !wr_stall && master_read) begin
        rd_acc++;
        rd_cyc.push_back(cyc);
        if (exp_rd_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexp_read: got read %08h expected none", master_address);
        end else check("read_addr", master_address, exp_rd_q.pop_front());
        pend_q.push_back('{cyc + lat, mem_data(master_address)});
      end
      if (!rst && !wr_stall && master_write) begin
        wr_acc++;
        if (exp_wr_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexp_write: got write %08h expected none", master_address);
        end else begin
          e = exp_wr_q.pop_front();
          check("write_addr", master_address, e.addr);
          check("write_data", master_writedata, e.data);
        end
      end
      if (rd_acc - wr_acc > max_inflight) max_inflight = rd_acc - wr_acc;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        master_readdatavalid = 1'b1;
        master_readdata      = pend_q.pop_front().data;
      end else begin
        master_readdatavalid = 1'b0;
        master_readdata      = '0;
      end
      prev_wait = wr_stall; prev_rst = rst; prev_rd = master_read; prev_wr = master_write;
      prev_addr = master_address; prev_wdata = master_writedata;
    end
  end

  task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    slave_address = a; slave_writedata = d; slave_write = 1'b1;
    @(negedge clk);
    slave_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    slave_address = a; slave_read = 1'b1;
    @(negedge clk);
    slave_read = 1'b0;
    d = slave_readdata;
  endtask

  task automatic start_job(input logic [31:0] src, input logic [31:0] dst, input int unsigned n,
                           input bit fill, input logic [31:0] fv);
    for (int unsigned i = 0; i < n; i++) begin
      if (!fill) exp_rd_q.push_back(src + 32'(4 * i));
      exp_wr_q.push_back('{dst + 32'(4 * i), fill ? fv : mem_data(src + 32'(4 * i))});
    end
    rd_acc = 0; wr_acc = 0; max_inflight = 0; rd_cyc.delete();
    reg_wr(REG_SRC, src);
    reg_wr(REG_DST, dst);
    reg_wr(REG_NWORDS, n);
    reg_wr(REG_MODE, {31'b0, fill});
    reg_wr(REG_FILL, fv);
    reg_wr(REG_CTRL, 32'd1);
  endtask

  task automatic finish_job(input string name, input int unsigned n);
    logic [31:0] s;
    int unsigned k;
    s = 32'd1;
    for (k = 0; k < 1000 && s[0]; k++) reg_rd(REG_CTRL, s);
    check({name, "_status"}, s, 32'd2);
    reg_rd(REG_DONECNT, s);
    check({name, "_donecnt"}, s, n);
    check({name, "_wr_left"}, exp_wr_q.size(), 0);
    check({name, "_rd_left"}, exp_rd_q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    n_fail++;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : main
    logic [31:0] s;
    rst = 1'b1;
    slave_address = '0; slave_read = 1'b0; slave_write = 1'b0; slave_writedata = '0;
    repeat (3) @(negedge clk);
    check("rst_mread", {31'b0, master_read}, 32'd0);
    check("rst_mwrite", {31'b0, master_write}, 32'd0);
    check("rst_maddr", master_address, 32'd0);
    check("rst_sdata", slave_readdata, 32'd0);
    rst = 1'b0;
    for (int unsigned r = 0; r < 7; r++) begin
      reg_rd(4'(r), s);
      check("rst_reg", s, 32'd0);
    end

    // Copy, zero-wait memory
    lat = 1; wait_rand = 1'b0;
    start_job(32'h100, 32'h200, 4, 1'b0, 32'h0);
    finish_job("copy", 4);

    // Fill
    start_job(32'h0, 32'h300, 3, 1'b1, 32'hA5A5_A5A5);
    finish_job("fill", 3);
    check("fill_reads", rd_acc, 0);

    // Back-pressure with latency 5; a register write while busy must be ignored
    lat = 5; wait_rand = 1'b1;
    start_job(32'h1000, 32'h2000, 20, 1'b0, 32'h0);
    reg_wr(REG_NWORDS, 32'd99);
    finish_job("bp", 20);
    check("bp_inflight_le8", {31'b0, max_inflight <= 8}, 32'd1);
    reg_rd(REG_NWORDS, s);
    check("busy_wr_ignored", s, 32'd20);

    // Long latency: credit limit reached, first reads back to back
    lat = 12; wait_rand = 1'b0;
    start_job(32'h3000, 32'h4000, 20, 1'b0, 32'h0);
    finish_job("credit", 20);
    check("credit_max", max_inflight, 32'd8);
    check("b2b_reads", rd_cyc[7] - rd_cyc[0], 32'd7);

    // Zero length
    lat = 1;
    reg_wr(REG_NWORDS, 32'd0);
    reg_wr(REG_MODE, 32'd0);
    @(posedge clk); #1 strobes = 0;
    reg_wr(REG_CTRL, 32'd1);
    reg_rd(REG_CTRL, s);
    check("zero_status", s, 32'd2);
    repeat (8) @(negedge clk);
    check("zero_strobes", strobes, 32'd0);

    // Unmapped address
    reg_wr(4'd9, 32'h1234_5678);
    reg_rd(4'd9, s);
    check("unmapped", s, 32'd0);

    // Address wrap
    start_job(32'hFFFF_FFF8, 32'h500, 3, 1'b0, 32'h0);
    finish_job("wrap", 3);

    // Reset mid-job with reads still in flight
    lat = 5;
    start_job(32'h5000, 32'h6000, 10, 1'b0, 32'h0);
    for (int unsigned k = 0; k < 500 && wr_acc < 2; k++) @(negedge clk);
    check("mid_reached", {31'b0, wr_acc >= 2}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    exp_rd_q.delete(); exp_wr_q.delete();
    @(posedge clk); #1;
    check("mid_mread", {31'b0, master_read}, 32'd0);
    check("mid_mwrite", {31'b0, master_write}, 32'd0);
    check("mid_maddr", master_address, 32'd0);
    check("mid_wdata", master_writedata, 32'd0);
    check("mid_sdata", slave_readdata, 32'd0);
    rst = 1'b0;
    strobes = 0;
    repeat (12) @(negedge clk);
    check("stale_strobes", strobes, 32'd0);
    reg_rd(REG_CTRL, s);
    check("stale_status", s, 32'd0);
    lat = 1;
    start_job(32'h7000, 32'h7100, 4, 1'b0, 32'h0);
    finish_job("after_rst", 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
